// File: rtl/k052109_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : k052109_pkg
// Description : Shared phase encodings, default raster constants and the
//               interrupt-flag bundle type for the 052109 timing generator.
// Revision    : 1.0
// ---------------------------------------------------------------------------
package k052109_pkg;

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;
  localparam logic [1:0] PH_3 = 2'd3;

  localparam int H_TOTAL_DEF  = 384;
  localparam int V_TOTAL_DEF  = 264;
  localparam int IRQ_LINE_DEF = 240;

  typedef struct packed {
    logic irq;
    logic firq;
    logic nmi;
  } irq_flags_t;

endpackage
`default_nettype wire

// File: rtl/k052109_irq_flag.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : k052109_irq_flag
// Description : Active-low interrupt request flag. Enable low forces the flag
//               inactive and takes priority over a same-cycle set.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module k052109_irq_flag (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_set,
  output logic o_flag_n
);

  logic r_flag_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_n <= 1'b1;
    end else if (!i_en) begin
      r_flag_n <= 1'b1;
    end else if (i_set) begin
      r_flag_n <= 1'b0;
    end
  end

  assign o_flag_n = r_flag_n;

endmodule
`default_nettype wire

// File: rtl/k052109_vtiming_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : k052109_vtiming_gen
// Description : Parametrised 052109 timing section: 6809 E/Q clocks, pixel
//               enable, raster counters, flip outputs, IRQ/FIRQ/NMI and RST.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module k052109_vtiming_gen
  import k052109_pkg::*;
#(
  parameter int HW          = 9,
  parameter int VW          = 9,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int IRQ_LINE    = IRQ_LINE_DEF,
  parameter int FIRQ_PERIOD = 2,
  parameter int NMI_PERIOD  = 32,
  parameter int RST_FRAMES  = 8
) (
  input  logic          M24,
  input  logic          RES,
  input  logic          IRQ_EN,
  input  logic          FIRQ_EN,
  input  logic          NMI_EN,
  input  logic          FLIP,
  output logic          M12,
  output logic          PE,
  output logic          PQ,
  output logic          PIX_CE,
  output logic [HW-1:0] H_CNT,
  output logic [VW-1:0] V_CNT,
  output logic [HW-1:0] HF,
  output logic [VW-1:0] VF,
  output logic          LINE_END,
  output logic          HVOT,
  output logic          IRQ,
  output logic          FIRQ,
  output logic          NMI,
  output logic          RST
);

  localparam logic [HW-1:0] c_h_last     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] c_v_last     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_irq_line   = VW'(IRQ_LINE);
  localparam logic [VW-1:0] c_firq_mask  = VW'(FIRQ_PERIOD - 1);
  localparam logic [VW-1:0] c_nmi_mask   = VW'(NMI_PERIOD - 1);
  localparam logic [7:0]    c_rst_frames = 8'(RST_FRAMES);

  logic          r_run;
  logic [1:0]    r_ph;
  logic [1:0]    w_ph_next;
  logic          r_m12;
  logic          r_pe;
  logic          r_pq;
  logic          r_pix_ce;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [VW-1:0] w_v_next;
  logic          w_line_end;
  logic          r_hvot;
  logic          r_line_start;
  logic [7:0]    r_frame_cnt;
  logic          r_rst;
  logic          w_irq_set;
  logic          w_firq_set;
  logic          w_nmi_set;
  irq_flags_t    w_flags;

  // The first edge after reset release only arms the phase counter, so
  // ph=0 is held for one full cycle before counting starts.
  assign w_ph_next = r_run ? r_ph + 2'd1 : r_ph;

  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      r_run    <= 1'b0;
      r_ph     <= PH_0;
      r_m12    <= 1'b1;
      r_pq     <= 1'b0;
      r_pe     <= 1'b0;
      r_pix_ce <= 1'b0;
    end else begin
      r_run    <= 1'b1;
      r_ph     <= w_ph_next;
      r_m12    <= (w_ph_next == PH_0) || (w_ph_next == PH_2);
      r_pq     <= (w_ph_next == PH_1) || (w_ph_next == PH_2);
      r_pe     <= (w_ph_next == PH_2) || (w_ph_next == PH_3);
      r_pix_ce <= (w_ph_next == PH_3);
    end
  end

  assign w_line_end = r_pix_ce && (r_h == c_h_last);

  always_comb begin
    w_v_next = r_v;
    if (w_line_end) begin
      w_v_next = (r_v == c_v_last) ? '0 : r_v + 1'b1;
    end
  end

  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      r_h          <= '0;
      r_v          <= '0;
      r_hvot       <= 1'b0;
      r_line_start <= 1'b0;
    end else begin
      if (r_pix_ce) begin
        r_h <= (r_h == c_h_last) ? '0 : r_h + 1'b1;
      end
      r_v          <= w_v_next;
      r_hvot       <= (w_v_next == c_v_last);
      r_line_start <= w_line_end;
    end
  end

  // Line-start events are evaluated against the freshly updated line number.
  assign w_irq_set  = r_line_start && (r_v == c_irq_line);
  assign w_firq_set = r_line_start && ((r_v & c_firq_mask) == '0);
  assign w_nmi_set  = r_line_start && ((r_v & c_nmi_mask) == '0);

  always_ff @(posedge M24 or posedge RES) begin
    if (RES) begin
      r_frame_cnt <= 8'd0;
      r_rst       <= 1'b1;
    end else begin
      if (w_irq_set && (r_frame_cnt != c_rst_frames)) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (r_frame_cnt == c_rst_frames) begin
        r_rst <= 1'b0;
      end
    end
  end

  k052109_irq_flag u_irq_flag (
    .clk      (M24),
    .rst      (RES),
    .i_en     (IRQ_EN),
    .i_set    (w_irq_set),
    .o_flag_n (w_flags.irq)
  );

  k052109_irq_flag u_firq_flag (
    .clk      (M24),
    .rst      (RES),
    .i_en     (FIRQ_EN),
    .i_set    (w_firq_set),
    .o_flag_n (w_flags.firq)
  );

  k052109_irq_flag u_nmi_flag (
    .clk      (M24),
    .rst      (RES),
    .i_en     (NMI_EN),
    .i_set    (w_nmi_set),
    .o_flag_n (w_flags.nmi)
  );

  assign M12      = r_m12;
  assign PE       = r_pe;
  assign PQ       = r_pq;
  assign PIX_CE   = r_pix_ce;
  assign H_CNT    = r_h;
  assign V_CNT    = r_v;
  assign HF       = r_h ^ {HW{FLIP}};
  assign VF       = r_v ^ {VW{FLIP}};
  assign LINE_END = w_line_end;
  assign HVOT     = r_hvot;
  assign IRQ      = w_flags.irq;
  assign FIRQ     = w_flags.firq;
  assign NMI      = w_flags.nmi;
  assign RST      = r_rst;

endmodule
`default_nettype wire

// File: tb/tb_k052109_vtiming_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_k052109_vtiming_gen
// Description : Directed self-checking bench; small raster (16x40) so several
//               frames fit in a short run. Revision 1.0
// ---------------------------------------------------------------------------
module tb_k052109_vtiming_gen;

  logic       M24 = 1'b0;
  logic       RES = 1'b1;
  logic       IRQ_EN = 1'b0;
  logic       FIRQ_EN = 1'b1;
  logic       NMI_EN = 1'b1;
  logic       FLIP = 1'b0;
  logic       M12, PE, PQ, PIX_CE, LINE_END, HVOT, IRQ, FIRQ, NMI, RST;
  logic [8:0] H_CNT, V_CNT, HF, VF;

  int n_chk = 0;
  int n_err = 0;
  int t = 0;

  k052109_vtiming_gen #(
    .HW(9), .VW(9), .H_TOTAL(16), .V_TOTAL(40), .IRQ_LINE(30),
    .FIRQ_PERIOD(2), .NMI_PERIOD(8), .RST_FRAMES(3)
  ) dut (
    .M24(M24), .RES(RES), .IRQ_EN(IRQ_EN), .FIRQ_EN(FIRQ_EN), .NMI_EN(NMI_EN),
    .FLIP(FLIP), .M12(M12), .PE(PE), .PQ(PQ), .PIX_CE(PIX_CE),
    .H_CNT(H_CNT), .V_CNT(V_CNT), .HF(HF), .VF(VF), .LINE_END(LINE_END),
    .HVOT(HVOT), .IRQ(IRQ), .FIRQ(FIRQ), .NMI(NMI), .RST(RST)
  );

  always #5 M24 = ~M24;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic tick();
    @(posedge M24);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  initial begin
    int le_cnt;
    int le_last;
    int ph;

    repeat (2) @(posedge M24);
    #1;
    check("rst_m12", M12, 1);
    check("rst_pe", PE, 0);
    check("rst_pq", PQ, 0);
    check("rst_pix", PIX_CE, 0);
    check("rst_h", H_CNT, 0);
    check("rst_v", V_CNT, 0);
    check("rst_hvot", HVOT, 0);
    check("rst_flags", {IRQ, FIRQ, NMI}, 3'b111);
    check("rst_rst", RST, 1);

    @(negedge M24);
    RES = 1'b0;
    t = 0;

    // Phase sequence 0,1,2,3,0,... one sample per cycle after release
    for (int i = 0; i < 8; i++) begin
      tick();
      ph = i % 4;
      check("ph_m12", M12, (ph == 0 || ph == 2) ? 1 : 0);
      check("ph_pq", PQ, (ph == 1 || ph == 2) ? 1 : 0);
      check("ph_pe", PE, (ph >= 2) ? 1 : 0);
      check("ph_pix", PIX_CE, (ph == 3) ? 1 : 0);
    end

    run_to(64);
    check("le_hi", LINE_END, 1);
    check("le_h", H_CNT, 15);
    check("le_v", V_CNT, 0);
    run_to(65);
    check("wrap_h", H_CNT, 0);
    check("wrap_v", V_CNT, 1);
    check("le_lo", LINE_END, 0);

    le_cnt = 0;
    le_last = 0;
    while (t < 128) begin
      tick();
      if (LINE_END) begin
        le_cnt++;
        le_last = t;
      end
    end
    check("le_count", le_cnt, 1);
    check("le_dist", le_last - 64, 64);

    // FIRQ: set at even lines, cleared by enable, clear beats set
    run_to(129);
    check("firq_pre", FIRQ, 1);
    run_to(130);
    check("firq_set2", FIRQ, 0);
    FIRQ_EN = 1'b0;
    run_to(131);
    check("firq_clr", FIRQ, 1);
    FIRQ_EN = 1'b1;
    run_to(194);
    check("firq_odd", FIRQ, 1);
    run_to(258);
    check("firq_set4", FIRQ, 0);
    FIRQ_EN = 1'b0;
    run_to(259);
    check("firq_clr4", FIRQ, 1);
    FIRQ_EN = 1'b1;
    run_to(385);
    check("firq_v6", V_CNT, 6);
    FIRQ_EN = 1'b0;
    run_to(386);
    check("firq_clrwin", FIRQ, 1);

    run_to(513);
    check("nmi_pre", NMI, 1);
    run_to(514);
    check("nmi_set8", NMI, 0);
    run_to(1000);
    check("nmi_hold", NMI, 0);
    NMI_EN = 1'b0;
    run_to(1001);
    check("nmi_clr", NMI, 1);

    run_to(1921);
    check("irq_v30", V_CNT, 30);
    run_to(1922);
    check("irq_dis", IRQ, 1);

    run_to(2496);
    check("hvot_pre", HVOT, 0);
    run_to(2497);
    check("hvot_v39", V_CNT, 39);
    check("hvot_on", HVOT, 1);
    run_to(2560);
    check("hvot_end", HVOT, 1);
    run_to(2561);
    check("vwrap_v", V_CNT, 0);
    check("hvot_off", HVOT, 0);

    run_to(3000);
    IRQ_EN = 1'b1;
    run_to(4481);
    check("irq_pre", IRQ, 1);
    run_to(4482);
    check("irq_set", IRQ, 0);
    IRQ_EN = 1'b0;
    run_to(4483);
    check("irq_clr", IRQ, 1);

    run_to(7042);
    check("rst_hold", RST, 1);
    run_to(7043);
    check("rst_rel", RST, 0);
    run_to(7100);
    check("rst_stay", RST, 0);
    IRQ_EN = 1'b1;
    FIRQ_EN = 1'b1;
    run_to(9602);
    check("irq_f3", IRQ, 0);

    run_to(9749);
    check("mid_h", H_CNT, 5);
    check("mid_v", V_CNT, 32);
    check("mid_firq", FIRQ, 0);
    FLIP = 1'b1;
    #1;
    check("flip_hf", HF, 9'h1FA);
    check("flip_vf", VF, 9'h1DF);
    FLIP = 1'b0;
    #1;
    check("noflip_hf", HF, 9'h005);
    RES = 1'b1;
    #1;
    check("ares_h", H_CNT, 0);
    check("ares_v", V_CNT, 0);
    check("ares_flags", {IRQ, FIRQ, NMI}, 3'b111);
    check("ares_rst", RST, 1);
    check("ares_m12", M12, 1);

    @(posedge M24);
    @(negedge M24);
    RES = 1'b0;
    t = 0;
    run_to(1);
    check("rel_m12", M12, 1);
    check("rel_pix1", PIX_CE, 0);
    run_to(3);
    check("rel_pix3", PIX_CE, 0);
    run_to(4);
    check("rel_pix4", PIX_CE, 1);
    check("rel_h4", H_CNT, 0);
    run_to(5);
    check("rel_h5", H_CNT, 1);
    check("rel_pix5", PIX_CE, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
